// File: rtl/imm_extend_unit.sv
// Pipelined immediate-extension unit: sign/zero/upper/branch extension of an
// IN_W-bit immediate into an OUT_W-bit operand, queued in a 2-entry output FIFO.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_ext
);

  localparam int PAD_W = OUT_W - IN_W;

  // Pure extension datapath; mode 11 is the sign-extended value scaled by 4.
  function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                  input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] res;
    sext = {{PAD_W{imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   res = sext;
      2'b01:   res = {{PAD_W{1'b0}}, imm};
      2'b10:   res = {imm, {PAD_W{1'b0}}};
      2'b11:   res = {sext[OUT_W-3:0], 2'b00};
      default: res = sext;
    endcase
    return res;
  endfunction

  logic [OUT_W-1:0] mem_q [2];
  logic [OUT_W-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_ext_q, out_ext_d;

  logic             push_s;
  logic             pop_s;
  logic [OUT_W-1:0] ext_s;

  assign ext_s  = extend_imm(in_imm, in_mode);
  assign push_s = in_valid && in_ready_q;
  assign pop_s  = out_valid_q && out_ready;

  // Next-state for FIFO storage, pointers, occupancy and the registered outputs.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      mem_d[0] = {OUT_W{1'b0}};
      mem_d[1] = {OUT_W{1'b0}};
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = ext_s;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    // Outputs are precomputed from next state so they come straight off flops.
    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
    out_ext_d   = mem_d[rd_ptr_d];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]    <= {OUT_W{1'b0}};
      mem_q[1]    <= {OUT_W{1'b0}};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ext_q   <= {OUT_W{1'b0}};
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_ext_q   <= out_ext_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ext   = out_ext_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed scenarios plus randomized
// traffic checked against an arithmetic reference model and a result queue.
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [31:0] out_ext;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [11:0] b_in_imm;
  logic [1:0]  b_in_mode;
  logic [31:0] b_out_ext;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  imm_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_ext(out_ext));

  imm_extend_unit #(.IN_W(12), .OUT_W(32)) dut12 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ext(b_out_ext));

  // Reference: extension from signed/unsigned integer arithmetic.
  function automatic logic [31:0] ref_ext(input int in_w, input logic [31:0] imm,
                                          input logic [1:0] mode);
    longint u, s;
    u = longint'(imm) & ((64'sd1 << in_w) - 64'sd1);
    s = (u >= (64'sd1 << (in_w - 1))) ? u - (64'sd1 << in_w) : u;
    case (mode)
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * (64'sd1 << (32 - in_w)));
      2'd3:    return 32'(s * 64'sd4);
      default: return 32'(s);
    endcase
  endfunction

  // Advance one clock on the main DUT, updating the queue model first.
  task automatic tick();
    bit acc, pop;
    acc = in_valid && (exp_q.size() != 2);
    pop = out_ready && (exp_q.size() != 0);
    if (rst || flush) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_ext(16, 32'(in_imm), in_mode));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tests += 4;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    if (out_ext !== 32'h0) begin fails++; $display("FAIL reset_out_ext got %h want 0", out_ext); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_dut12 got v=%0b r=%0b want v=0 r=1", b_out_valid, b_in_ready);
    end
  endtask

  task automatic test_modes();
    logic [15:0] imms [6] = '{16'h8001, 16'h7FFF, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF};
    logic [1:0]  modes[6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] exps [6] = '{32'hFFFF8001, 32'h00007FFF, 32'h00008001,
                              32'h12340000, 32'hFFFFFFFC, 32'h0001FFFC};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_imm = imms[i]; in_mode = modes[i];
      tick();
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_ext !== exps[i]) begin
        fails++; $display("FAIL mode%0d got v=%0b %h want v=1 %h", i, out_valid, out_ext, exps[i]);
      end
      tick();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL mode%0d_drain got v=%0b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8);
      in_imm = 16'($urandom); in_mode = 2'(i);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready cyc%0d got %0b want 1", i, in_ready); end
      if (i > 0) begin
        tests++;
        if (exp_q.size() == 0 || out_valid !== 1'b1 || out_ext !== exp_q[0]) begin
          fails++; $display("FAIL b2b_result cyc%0d got v=%0b %h want v=1 %h", i, out_valid, out_ext,
                            (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got v=%0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_mode = 2'd1; in_valid = 1'b1;
    in_imm = 16'h0001; tick();
    in_imm = 16'h0002;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %0b want 1", in_ready); end
    tick();
    in_imm = 16'h0003;
    for (int i = 0; i < 2; i++) begin
      tests += 2;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %0b want 0", in_ready); end
      if (out_valid !== 1'b1 || out_ext !== 32'h1) begin
        fails++; $display("FAIL bp_hold got v=%0b %h want v=1 1", out_valid, out_ext);
      end
      tick();
    end
    out_ready = 1'b1;
    tests++;
    if (out_ext !== 32'h1) begin fails++; $display("FAIL bp_out1 got %h want 1", out_ext); end
    tick();
    tests += 2;
    if (out_ext !== 32'h2) begin fails++; $display("FAIL bp_out2 got %h want 2", out_ext); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_free got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_ext !== 32'h3) begin
      fails++; $display("FAIL bp_out3 got v=%0b %h want v=1 3", out_valid, out_ext);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got v=%0b want 0", out_valid); end
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h00AA; in_mode = 2'd0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_imm = 16'($urandom); in_mode = 2'($urandom);
      tests++;
      if (exp_q.size() != 1 || out_valid !== 1'b1 || in_ready !== 1'b1 || out_ext !== exp_q[0]) begin
        fails++; $display("FAIL simul cyc%0d got v=%0b r=%0b %h depth=%0d", i, out_valid, in_ready,
                          out_ext, exp_q.size());
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd1;
    in_imm = 16'h0011; tick();
    in_imm = 16'h0022; tick();
    in_imm = 16'hDEAD; in_mode = 2'd0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %0b want 1", in_ready); end
    if (out_ext !== 32'h0) begin fails++; $display("FAIL flush_ext got %h want 0", out_ext); end
    in_valid = 1'b1; in_imm = 16'h0033; tick();
    in_imm = 16'hBEEF; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_emit cyc%0d got v=%0b %h", i, out_valid, out_ext); end
      tick();
    end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h1357; in_mode = 2'd1;
    tick();
    rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_ext !== 32'h0) begin
      fails++; $display("FAIL rst_mid got v=%0b %h want v=0 0", out_valid, out_ext);
    end
    in_valid = 1'b1; in_imm = 16'h8000; in_mode = 2'd0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_ext !== 32'hFFFF8000) begin
      fails++; $display("FAIL rst_after got v=%0b %h want v=1 ffff8000", out_valid, out_ext);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_imm = 16'($urandom); in_mode = 2'($urandom);
      tests++;
      if (in_ready !== (exp_q.size() != 2) || out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && out_ext !== exp_q[0])) begin
        fails++; $display("FAIL random cyc%0d got v=%0b r=%0b %h want depth=%0d head=%h", i,
                          out_valid, in_ready, out_ext, exp_q.size(),
                          (exp_q.size() != 0) ? exp_q[0] : 32'h0);
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_param_sweep();
    logic [11:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
    b_out_ready = 1'b1; b_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin imm = 12'h800; mode = 2'd0; end
      else if (i == 1) begin imm = 12'hABC; mode = 2'd2; end
      else begin imm = 12'($urandom); mode = 2'($urandom); end
      b_in_imm = imm; b_in_mode = mode;
      exp = (i == 0) ? 32'hFFFFF800 : (i == 1) ? 32'hABC00000 : ref_ext(12, 32'(imm), mode);
      @(posedge clk); #1;
      tests++;
      if (b_out_valid !== 1'b1 || b_out_ext !== exp) begin
        fails++; $display("FAIL w12_%0d got v=%0b %h want v=1 %h", i, b_out_valid, b_out_ext, exp);
      end
    end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = 16'h0; in_mode = 2'd0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_imm = 12'h0; b_in_mode = 2'd0; b_out_ready = 1'b0;
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_simul_push_pop();
    test_flush();
    test_rst_mid();
    test_random();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, pipelined immediate-extension unit for the processor datapath. It accepts an IN_W-bit immediate field plus a 2-bit mode. It produces an OUT_W-bit operand in one of four modes: sign-extend, zero-extend, upper-placement, or sign-extend-and-shift-left-2 for branch offsets. Results pass through a 2-entry output buffer with valid/ready handshakes on both sides, so the unit can sit between decode and execute stages that stall independently.

## Interface
- IN_W, 16, width of the immediate field.
- OUT_W, 32, width of the extended result; legal only when OUT_W >= IN_W+2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous buffer clear, lower priority than rst.
- in_valid  input  1  upstream presents in_imm/in_mode.
- in_ready  output  1  unit can accept this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch (sign, <<2).
- out_valid  output  1  out_ext holds a valid result.
- out_ready  input  1  downstream takes the result this cycle.
- out_ext  output  OUT_W  extended result at buffer head.

## Operation
- Extension is computed combinationally from in_imm/in_mode and written into the buffer on accept (in_valid && in_ready).
- Mode 00: replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
- Mode 01: zeros in bits OUT_W-1..IN_W.
- Mode 10: in_imm in bits OUT_W-1..OUT_W-IN_W, zeros below.
- Mode 11: the mode-00 result shifted left by 2 and truncated to OUT_W bits; bits 1..0 = 0.
- Buffer: 2-entry circular FIFO with 1-bit read pointer, 1-bit write pointer, and a 2-bit count (0..2).
- in_ready = (count != 2). Depends on registered state only; no combinational path from out_ready.
- out_valid = (count != 0). out_ext = entry at the read pointer.
- Pop when out_valid && out_ready. Push on accept.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Count = 2: in_ready = 0, so no push. A pop makes in_ready = 1 in the next cycle.
- Count = 0 with out_ready = 1: no pop and no underflow. A push in that cycle appears next cycle; there is no same-cycle bypass.
- Pointers wrap 1 -> 0.
- Results leave strictly in acceptance order.
- flush = 1: count, pointers, and out_ext storage are cleared next edge. Any in_valid in the same cycle is discarded.
- rst = 1: same effect as flush and overrides it. Legal mid-transfer: any queued results are lost.

## Timing
- Reset values: out_valid = 0, out_ext = 0, in_ready = 1 in the first cycle after rst deasserts; count = 0, pointers = 0.
- Latency: accepted at edge N, out_valid = 1 with the correct out_ext after edge N, stable for the whole of cycle N+1.
- Throughput: 1 result/cycle sustained while out_ready = 1.
- out_ext and out_valid hold stable while out_valid && !out_ready.
- Following a flush or rst edge: out_valid = 0 and in_ready = 1 in the next cycle.

## Test plan
- Modes, with out_ready = 1 and each result 1 cycle after accept:
  - mode 00, in_imm = 16'h8001 -> 32'hFFFF8001
  - mode 00, in_imm = 16'h7FFF -> 32'h00007FFF
  - mode 01, in_imm = 16'h8001 -> 32'h00008001
  - mode 10, in_imm = 16'h1234 -> 32'h12340000
  - mode 11, in_imm = 16'hFFFF -> 32'hFFFFFFFC
  - mode 11, in_imm = 16'h7FFF -> 32'h0001FFFC
- Back-to-back 8 pushes with out_ready = 1 (mixed modes) -> 8 results on consecutive cycles, in order, in_ready constantly 1.
- Backpressure: out_ready = 0, offer 16'h0001, 16'h0002, 16'h0003 (mode 01):
  - in_ready drops after the 2nd accept.
  - Raising out_ready -> outputs 32'h1, 32'h2, then 32'h3 (accepted once space frees), none lost or duplicated.
- Simultaneous push/pop at count = 1 over 5 cycles -> count stays 1, results in order.
- Flush with count = 2 and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, flushed input never emitted.
- rst asserted mid-stream with count = 1 -> out_valid = 0, out_ext = 0 next cycle. After release, 16'h8000 in mode 00 -> 32'hFFFF8000.
- Re-run a parameter sweep with IN_W = 12, OUT_W = 32: mode 00 on 12'h800 -> 32'hFFFFF800; mode 10 on 12'hABC -> 32'hABC00000.
